// File: rtl/pin_entry_ctrl.sv
// Keypad front end for the 16-bit hex PIN comparator.
// Collects four digits, strobes them for checking, tracks retries and lockout.
module pin_entry_ctrl #(
  parameter int MAX_TRIES      = 3,
  parameter int TRY_W          = 2,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             key_enter,
  input  logic             key_clear,
  input  logic             unlock_in,
  output logic [15:0]      pin,
  output logic             pin_valid,
  output logic [2:0]       digit_count,
  output logic [TRY_W-1:0] tries_left,
  output logic             unlocked,
  output logic             locked_out,
  output logic             fail
);

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRY_ONE = TRY_W'(1);

  // One-hot so each status output is a plain flop bit.
  typedef enum logic [3:0] {
    ENTRY   = 4'b0001,
    CHECK   = 4'b0010,
    OPEN    = 4'b0100,
    LOCKOUT = 4'b1000
  } state_t;

  state_t state;
  state_t state_next;

  logic [LW-1:0] lock_cnt;
  logic [IW-1:0] idle_cnt;
  logic          any_key;
  logic          full;
  logic          lock_done;

  assign any_key   = key_valid | key_enter | key_clear;
  assign full      = (digit_count == 3'd4);
  assign lock_done = (lock_cnt == LOCK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ENTRY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ENTRY: begin
        if (!key_clear && key_enter && full) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (unlock_in) begin
          state_next = OPEN;
        end else if (tries_left == TRY_ONE) begin
          state_next = LOCKOUT;
        end else begin
          state_next = ENTRY;
        end
      end
      OPEN: begin
        if (key_clear) begin
          state_next = ENTRY;
        end
      end
      LOCKOUT: begin
        if (lock_done) begin
          state_next = ENTRY;
        end
      end
      default: state_next = ENTRY;
    endcase
  end

  always_comb begin
    pin_valid  = (state == CHECK);
    unlocked   = (state == OPEN);
    locked_out = (state == LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pin         <= '0;
      digit_count <= '0;
      tries_left  <= TRY_MAX;
      fail        <= 1'b0;
      lock_cnt    <= '0;
      idle_cnt    <= '0;
    end else begin
      fail     <= (state == CHECK) && !unlock_in;
      lock_cnt <= '0;
      idle_cnt <= '0;
      unique case (state)
        ENTRY: begin
          if (key_clear) begin
            pin         <= '0;
            digit_count <= '0;
          end else if (key_enter) begin
            // A short entry is discarded; a full one is held for CHECK.
            if (!full) begin
              pin         <= '0;
              digit_count <= '0;
            end
          end else if (key_valid) begin
            if (!full) begin
              pin         <= {pin[11:0], key_code};
              digit_count <= digit_count + 3'd1;
            end
          end else if (digit_count != 3'd0) begin
            if (idle_cnt == IDLE_LAST) begin
              pin         <= '0;
              digit_count <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          if (any_key) begin
            idle_cnt <= '0;
          end
        end
        CHECK: begin
          pin         <= '0;
          digit_count <= '0;
          if (unlock_in) begin
            tries_left <= TRY_MAX;
          end else begin
            tries_left <= tries_left - TRY_ONE;
          end
        end
        OPEN: begin
        end
        LOCKOUT: begin
          if (lock_done) begin
            tries_left <= TRY_MAX;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/pin_entry_ctrl.md
Name: pin_entry_ctrl

Overview:
Sequential keypad-side front end for the 16-bit hex PIN comparator. Collects four hex digits from a keypad strobe interface, presents the assembled 16-bit PIN with a one-cycle validate strobe, and samples the comparator's unlock result. Manages retry counting, lockout and relock, and sits between the keypad scanner and the combinational PIN compare block.

Parameters:
MAX_TRIES, 3, failed attempts allowed before lockout (1..2^TRY_W-1)
TRY_W, 2, width of tries_left
LOCKOUT_CYCLES, 1000, clk cycles spent in LOCKOUT (>=1)
TIMEOUT_CYCLES, 5000, idle cycles after which a partial entry is discarded (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
key_valid  input  1  one-cycle strobe: key_code holds a digit
key_code  input  4  hex digit 0x0-0xF
key_enter  input  1  one-cycle strobe: submit entry
key_clear  input  1  one-cycle strobe: discard entry / relock
unlock_in  input  1  comparator result for the current pin, combinational, sampled in CHECK
pin  output  16  assembled PIN; first digit ends in pin[15:12]
pin_valid  output  1  high exactly during the CHECK cycle
digit_count  output  3  digits entered, 0..4
tries_left  output  TRY_W  remaining attempts
unlocked  output  1  high in OPEN
locked_out  output  1  high in LOCKOUT
fail  output  1  one-cycle pulse on a rejected attempt

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: state=ENTRY, pin=0, digit_count=0, tries_left=MAX_TRIES, pin_valid=0, unlocked=0, locked_out=0, fail=0. The lockout and idle counters reset to 0.
- States: ENTRY, CHECK, OPEN, LOCKOUT.
- Key priority when strobes coincide: key_clear > key_enter > key_valid. Lower-priority strobes are dropped.
- ENTRY state:
  - key_valid with digit_count<4: pin <= {pin[11:0], key_code}, digit_count++.
  - key_valid with digit_count==4: ignored.
  - key_clear: pin=0, digit_count=0. No attempt is consumed.
  - key_enter with digit_count==4: go to CHECK next cycle.
  - key_enter with digit_count<4: clear the entry, no attempt consumed, stay in ENTRY.
- Idle timeout in ENTRY: the idle counter resets on any key strobe and counts while digit_count>0. On reaching TIMEOUT_CYCLES, clear pin and digit_count. No attempt is consumed.
- CHECK state: lasts exactly 1 cycle with pin_valid=1 and pin held stable. unlock_in is sampled in this cycle.
  - unlock_in=1: next state OPEN, tries_left reloads to MAX_TRIES.
  - unlock_in=0: fail pulses 1 cycle in the cycle after CHECK, tries_left--.
    - If the decremented value is 0: next state LOCKOUT.
    - Otherwise: next state ENTRY.
  - In both cases pin and digit_count clear on leaving CHECK.
  - Keys strobed during CHECK are ignored.
- Latency: key_enter in cycle N gives pin_valid in cycle N+1. unlocked, fail or locked_out assert in cycle N+2.
- OPEN state: unlocked=1. Only key_clear acts: it returns to ENTRY with unlocked=0 next cycle. key_valid and key_enter are ignored.
- LOCKOUT state: locked_out=1 and all keys are ignored. The counter runs LOCKOUT_CYCLES cycles, then the block returns to ENTRY with tries_left=MAX_TRIES and locked_out=0.
- Reset mid-operation (any state): immediate return to reset values on the next edge. A lockout in progress is cancelled.
- pin holds its value between events. Its value is meaningful to downstream logic only while pin_valid=1.

Test Plan:
1. Reset, then keys A,B,C,7, then enter, with the comparator (password 16'hABC7) in the bench. Required: pin=16'hABC7 and pin_valid=1 for 1 cycle, then unlocked=1 and tries_left=3. key_clear then gives unlocked=0 and state ENTRY.
2. Keys 1,2,3,4 plus enter, three times. Required: fail pulses each time; tries_left goes 2, 1, 0; locked_out=1 after the third attempt. Keys during lockout are ignored (digit_count stays 0). After 1000 cycles locked_out=0 and tries_left=3.
3. Keys A,B,C,7,5, then enter. Required: the fifth key is ignored, digit_count=4, and the result is unlocked. Separately, keys A,B plus enter: entry cleared, tries_left unchanged, no pin_valid.
4. Keys A,B, then idle TIMEOUT_CYCLES cycles. Required: digit_count=0 and pin=0. Also: key_valid, key_enter and key_clear asserted in the same cycle. Required: clear wins, no CHECK.
5. One wrong entry (tries_left=2), then a correct entry. Required: tries_left reloads to 3. Also: assert rst during LOCKOUT. Required: all outputs return to reset values on the next edge.
